// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode map, instruction field positions and opcode classification.
package isa_pkg;

  localparam int unsigned OPC_W  = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned WORD_W = 32;

  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned DEST_LO = 21;
  localparam int unsigned SRC1_LO = 16;
  localparam int unsigned SRC2_LO = 11;
  localparam int unsigned IMM_LO  = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADD  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'b000011;
  localparam logic [OPC_W-1:0] OP_AND  = 6'b000101;
  localparam logic [OPC_W-1:0] OP_OR   = 6'b000110;
  localparam logic [OPC_W-1:0] OP_NOR  = 6'b000111;
  localparam logic [OPC_W-1:0] OP_XOR  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SLA  = 6'b001001;
  localparam logic [OPC_W-1:0] OP_SLL  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_SRA  = 6'b001011;
  localparam logic [OPC_W-1:0] OP_SRL  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b100000;
  localparam logic [OPC_W-1:0] OP_SUBI = 6'b100001;
  localparam logic [OPC_W-1:0] OP_LD   = 6'b100100;
  localparam logic [OPC_W-1:0] OP_ST   = 6'b100101;
  localparam logic [OPC_W-1:0] OP_BEZ  = 6'b101000;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b101001;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'b101010;
  localparam logic [OPC_W-1:0] OP_SWP  = 6'b111111;

  typedef enum logic [1:0] {
    PAD_NONE = 2'd0,
    PAD_BR   = 2'd1,
    PAD_SWP  = 2'd2
  } pad_kind_t;

  function automatic logic is_rtype(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
      OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: is_rtype = 1'b1;
      default:                                is_rtype = 1'b0;
    endcase
  endfunction

  function automatic logic is_itype(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_LD, OP_ST,
      OP_BEZ, OP_BNE, OP_JMP: is_itype = 1'b1;
      default:                is_itype = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [OPC_W-1:0] op);
    is_branch = (op == OP_BEZ) || (op == OP_BNE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: opcode plus decoded fields to a 32-bit word, legality and pad class.
module instr_field_pack
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_W-1:0]  dest,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic [IMM_W-1:0]  imm,
  output logic              legal_c,
  output logic [WORD_W-1:0] word_c,
  output pad_kind_t         pad_kind_c
);

  always_comb begin
    legal_c    = 1'b1;
    word_c     = '0;
    pad_kind_c = PAD_NONE;
    word_c[OPC_LO +: OPC_W] = opcode;
    if (is_rtype(opcode)) begin
      word_c[DEST_LO +: REG_W] = dest;
      word_c[SRC1_LO +: REG_W] = src1;
      word_c[SRC2_LO +: REG_W] = src2;
    end else if (is_itype(opcode)) begin
      // stores and compare-branches have no destination; src2 rides in the dest slot
      if (opcode == OP_ST || opcode == OP_BNE) begin
        word_c[DEST_LO +: REG_W] = src2;
      end else begin
        word_c[DEST_LO +: REG_W] = dest;
      end
      word_c[SRC1_LO +: REG_W] = src1;
      word_c[IMM_LO +: IMM_W]  = imm;
      if (is_branch(opcode)) begin
        pad_kind_c = PAD_BR;
      end
    end else if (opcode == OP_SWP) begin
      pad_kind_c = PAD_SWP;
    end else if (opcode != OP_NOP) begin
      legal_c = 1'b0;
      word_c  = '0;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: valid/ready field bundles in, encoded words out, with NOP padding
// after branches and SWP so dependent instructions never reach decode early.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned BR_PAD  = 1,
  parameter int unsigned SWP_PAD = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [REG_W-1:0]  in_src1,
  input  logic [REG_W-1:0]  in_src2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned PAD_W = 3;

  typedef enum logic {IDLE = 1'b0, PAD = 1'b1} state_t;

  state_t             state, state_d;
  logic [PAD_W-1:0]   pad_cnt, pad_cnt_d;
  logic               out_valid_d;
  logic [WORD_W-1:0]  out_word_d;
  logic               err_illegal_d;
  logic [CNT_W-1:0]   word_count_d;

  logic               legal_c;
  logic [WORD_W-1:0]  word_c;
  pad_kind_t          pad_kind_c;
  logic               out_free;
  logic               accept;

  instr_field_pack u_pack (
    .opcode     (in_opcode),
    .dest       (in_dest),
    .src1       (in_src1),
    .src2       (in_src2),
    .imm        (in_imm),
    .legal_c    (legal_c),
    .word_c     (word_c),
    .pad_kind_c (pad_kind_c)
  );

  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Next-state, output register and counter update
  always_comb begin
    state_d       = state;
    pad_cnt_d     = pad_cnt;
    out_valid_d   = out_valid && !out_ready;
    out_word_d    = out_word;
    err_illegal_d = 1'b0;
    word_count_d  = word_count + CNT_W'(out_valid && out_ready);
    case (state)
      IDLE: begin
        if (accept) begin
          if (legal_c) begin
            out_valid_d = 1'b1;
            out_word_d  = word_c;
            if (pad_kind_c == PAD_BR && BR_PAD > 0) begin
              state_d   = PAD;
              pad_cnt_d = PAD_W'(BR_PAD);
            end else if (pad_kind_c == PAD_SWP && SWP_PAD > 0) begin
              state_d   = PAD;
              pad_cnt_d = PAD_W'(SWP_PAD);
            end
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_word_d  = '0;
          pad_cnt_d   = pad_cnt - PAD_W'(1);
          if (pad_cnt == PAD_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pad_cnt     <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      err_illegal <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_d;
      pad_cnt     <= pad_cnt_d;
      out_valid   <= out_valid_d;
      out_word    <= out_word_d;
      err_illegal <= err_illegal_d;
      word_count  <= word_count_d;
    end
  end

endmodule
